elastic_input_buffer: RTL

ELASTIC_INPUT_BUFFER -- requirements
Module: elastic_input_buffer

---
 rtl/elastic_input_buffer_pkg.sv | 13 +
 rtl/elastic_input_buffer_if.sv | 24 ++
 rtl/elastic_input_buffer.sv | 86 ++++++++
 3 files changed

// File: rtl/elastic_input_buffer_pkg.sv
// Shared constants and helpers for the elastic input buffer.
// DATA_WIDTH and NEIGHBOR_PE_NUM stand in for the shared param.v values.
package elastic_input_buffer_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int NEIGHBOR_PE_NUM = 4;

  // Saturating 32-bit increment used by the optional stall counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/elastic_input_buffer_if.sv
// Valid/stop handshake bundle for one PE input lane: upstream side and
// downstream (PE input multiplexer) side of the elastic buffer.
interface elastic_input_buffer_if
  import elastic_input_buffer_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);
  logic [WIDTH-1:0] data_input;
  logic             valid_input;
  logic             stop_input;
  logic [WIDTH-1:0] data_output;
  logic             valid_output;
  logic             stop_output;

  modport slave (
    input  data_input, valid_input, stop_output,
    output stop_input, data_output, valid_output
  );

  modport master (
    output data_input, valid_input, stop_output,
    input  stop_input, data_output, valid_output
  );
endinterface

// File: rtl/elastic_input_buffer.sv
// First-word-fall-through elastic buffer, DEPTH entries, registered stop.
// Optional stall counter enabled by ELASTIC_BUFFER_STALL_COUNT_EN.
module elastic_input_buffer
  import elastic_input_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  elastic_input_buffer_if.slave  bus
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, not_empty, push, pop;

  // Status comes only from count_q so stop_input has no path from stop_output.
  assign full      = (count_q == FULL);
  assign not_empty = (count_q != '0);
  assign push      = bus.valid_input && !full;
  assign pop       = not_empty && !bus.stop_output;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.data_input;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; cleared pointers hide stale words.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.stop_input   = full;
  assign bus.valid_output = not_empty;
  assign bus.data_output  = mem_q[rd_ptr_q];

`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (not_empty && bus.stop_output) stall_d = sat_inc32(stall_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule
